// File: rtl/lcd_linebuf_arb.sv
// Line-RAM arbiter: the PPU pixel writer (through a small FIFO) and the scan-out reader
// share one single-port 512x2 RAM. The writer fills bank `bank`, and the reader drains ~bank.
module lcd_linebuf_arb #(
  parameter int DEPTH  = 4,
  parameter int THRESH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic                     pix_we,
  input  logic [1:0]               pix_data,
  input  logic                     rd_req,
  input  logic [7:0]               rd_ptr,
  output logic                     rd_ack,
  output logic                     rd_valid,
  output logic [1:0]               rd_data,
  output logic [8:0]               ram_addr,
  output logic                     ram_we,
  output logic [1:0]               ram_wdata,
  input  logic [1:0]               ram_rdata,
  output logic                     bank,
  output logic [7:0]               wr_ptr,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic       bnk;
    logic [7:0] idx;
    logic [1:0] pix;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head_e;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    last_mode_q;
  logic          bank_q, bank_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic          rd_ack_q, rd_valid_q, ram_we_q;
  logic [8:0]    ram_addr_q, ram_addr_d;
  logic [1:0]    ram_wdata_q, ram_wdata_d, rd_hold_q;
  logic          swap, thr_hit, do_rd, do_wr, push;

  // Arbitration decision on current state; the command reaches the RAM port next cycle.
  always_comb begin
    head_e  = mem_q[head_q];
    swap    = (last_mode_q == 2'b00) && (mode != 2'b00);
    thr_hit = int'(count_q) >= THRESH;
    do_rd   = !thr_hit && rd_req && !rd_ack_q;
    do_wr   = (count_q != '0) && !do_rd;
    push    = pix_we && ((count_q != FULL) || do_wr);
    ovf_d   = ovf_q | (pix_we & ~push);

    bank_d   = swap ? ~bank_q : bank_q;
    wr_ptr_d = wr_ptr_q;
    if (pix_we) wr_ptr_d = wr_ptr_q + 8'd1;
    if (swap)   wr_ptr_d = 8'd0;

    head_d = do_wr ? head_q + AW'(1) : head_q;
    tail_d = push  ? tail_q + AW'(1) : tail_q;
    case ({push, do_wr})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (do_wr) begin
      ram_addr_d  = {head_e.bnk, head_e.idx};
      ram_wdata_d = head_e.pix;
    end else if (do_rd) begin
      ram_addr_d = {~bank_q, rd_ptr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[tail_q] <= '{bnk: bank_q, idx: wr_ptr_q, pix: pix_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_mode_q <= 2'b01;
      bank_q      <= 1'b0;
      wr_ptr_q    <= 8'd0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 9'd0;
      ram_wdata_q <= 2'd0;
      rd_hold_q   <= 2'd0;
    end else begin
      last_mode_q <= mode;
      bank_q      <= bank_d;
      wr_ptr_q    <= wr_ptr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      rd_ack_q    <= do_rd;
      ram_we_q    <= do_wr;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      // RAM data arrives the cycle after rd_ack; hold it until the next read returns.
      rd_valid_q  <= rd_ack_q;
      if (rd_valid_q) rd_hold_q <= ram_rdata;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? ram_rdata : rd_hold_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign bank       = bank_q;
  assign wr_ptr     = wr_ptr_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_lcd_linebuf_arb.sv
// Directed bench for lcd_linebuf_arb with a behavioural 512x2 synchronous RAM.
// A second instance with THRESH above DEPTH lets the write FIFO actually fill up.
module tb_lcd_linebuf_arb;
  logic       clk, reset_n;
  logic [1:0] mode, pix_data, ram_rdata, rd_data, ram_wdata;
  logic       pix_we, rd_req, rd_ack, rd_valid, ram_we, bank, overflow;
  logic [7:0] rd_ptr, wr_ptr;
  logic [8:0] ram_addr;
  logic [2:0] fifo_level;

  logic       o_rd_ack, o_rd_valid, o_ram_we, o_bank, o_overflow;
  logic [1:0] o_rd_data, o_ram_wdata;
  logic [1:0] o_ram_rdata;
  logic [8:0] o_ram_addr;
  logic [7:0] o_wr_ptr;
  logic [2:0] o_fifo_level;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  ram [512];
  logic [10:0] wlog[$];

  lcd_linebuf_arb #(.DEPTH(4), .THRESH(3)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .pix_we(pix_we), .pix_data(pix_data),
    .rd_req(rd_req), .rd_ptr(rd_ptr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .bank(bank), .wr_ptr(wr_ptr), .fifo_level(fifo_level), .overflow(overflow)
  );

  lcd_linebuf_arb #(.DEPTH(4), .THRESH(5)) u_ovf (
    .clk(clk), .reset_n(reset_n), .mode(mode), .pix_we(pix_we), .pix_data(pix_data),
    .rd_req(rd_req), .rd_ptr(rd_ptr), .rd_ack(o_rd_ack), .rd_valid(o_rd_valid),
    .rd_data(o_rd_data), .ram_addr(o_ram_addr), .ram_we(o_ram_we), .ram_wdata(o_ram_wdata),
    .ram_rdata(o_ram_rdata), .bank(o_bank), .wr_ptr(o_wr_ptr), .fifo_level(o_fifo_level),
    .overflow(o_overflow)
  );

  assign o_ram_rdata = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
    ram_rdata <= ram[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mode = 2'b10; pix_we = 1'b0; pix_data = 2'b00;
    rd_req = 1'b0; rd_ptr = 8'd0;

    // Reset, then idle in oam mode: no swap from the reset value of last_mode.
    tick(); tick();
    chk("rst_rd_ack", 16'(rd_ack), 16'd0);
    chk("rst_rd_valid", 16'(rd_valid), 16'd0);
    chk("rst_rd_data", 16'(rd_data), 16'd0);
    chk("rst_ram_addr", 16'(ram_addr), 16'd0);
    chk("rst_ram_we", 16'(ram_we), 16'd0);
    chk("rst_ram_wdata", 16'(ram_wdata), 16'd0);
    chk("rst_bank", 16'(bank), 16'd0);
    chk("rst_wr_ptr", 16'(wr_ptr), 16'd0);
    chk("rst_level", 16'(fifo_level), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_bank", 16'(bank), 16'd0);
    chk("idle_ram_we", 16'(ram_we), 16'd0);

    // Line fill: 160 pixels every other cycle into bank 0.
    for (int i = 0; i < 160; i++) begin
      pix_we = 1'b1; pix_data = 2'(i % 4);
      tick();
      pix_we = 1'b0;
      tick();
    end
    tick(); tick();
    chk("fill_count", 16'(wlog.size()), 16'd160);
    for (int i = 0; i < 160; i++)
      chk("fill_wr", 16'(wlog[i]), 16'((i << 2) | (i % 4)));
    chk("fill_bank", 16'(bank), 16'd0);
    chk("fill_wr_ptr", 16'(wr_ptr), 16'd160);
    chk("fill_overflow", 16'(overflow), 16'd0);
    chk("fill_level", 16'(fifo_level), 16'd0);

    // Swap at end of hblank, then read index 5 from the display bank.
    mode = 2'b00; tick();
    mode = 2'b10; tick();
    chk("swap_bank", 16'(bank), 16'd1);
    chk("swap_wr_ptr", 16'(wr_ptr), 16'd0);
    rd_req = 1'b1; rd_ptr = 8'd5;
    tick();
    chk("rd_ack", 16'(rd_ack), 16'd1);
    chk("rd_addr", 16'(ram_addr), 16'h005);
    chk("rd_we", 16'(ram_we), 16'd0);
    chk("rd_valid_early", 16'(rd_valid), 16'd0);
    rd_req = 1'b0;
    tick();
    chk("rd_ack_drop", 16'(rd_ack), 16'd0);
    chk("rd_valid", 16'(rd_valid), 16'd1);
    chk("rd_data", 16'(rd_data), 16'd1);
    tick();
    chk("rd_valid_end", 16'(rd_valid), 16'd0);
    chk("rd_data_hold", 16'(rd_data), 16'd1);

    // Contention: build the FIFO to THRESH while reads are pending.
    rd_req = 1'b1; rd_ptr = 8'd10; pix_we = 1'b1; pix_data = 2'b11;
    tick();
    chk("c0_ack", 16'(rd_ack), 16'd1);
    chk("c0_addr", 16'(ram_addr), 16'h00A);
    chk("c0_level", 16'(fifo_level), 16'd1);
    rd_ptr = 8'd11; pix_data = 2'b10;
    tick();
    chk("c1_we", 16'(ram_we), 16'd1);
    chk("c1_addr", 16'(ram_addr), 16'h100);
    chk("c1_wdata", 16'(ram_wdata), 16'd3);
    chk("c1_rd_data", 16'(rd_data), 16'd2);
    pix_data = 2'b01;
    tick();
    chk("c2_ack", 16'(rd_ack), 16'd1);
    chk("c2_addr", 16'(ram_addr), 16'h00B);
    chk("c2_level", 16'(fifo_level), 16'd2);
    rd_ptr = 8'd12; pix_data = 2'b00;
    tick();
    chk("c3_addr", 16'(ram_addr), 16'h101);
    chk("c3_wdata", 16'(ram_wdata), 16'd2);
    chk("c3_rd_data", 16'(rd_data), 16'd3);
    pix_data = 2'b01;
    tick();
    chk("c4_ack", 16'(rd_ack), 16'd1);
    chk("c4_level", 16'(fifo_level), 16'd3);
    pix_we = 1'b0; rd_ptr = 8'd13;
    tick();
    chk("c5_we_first", 16'(ram_we), 16'd1);
    chk("c5_ack", 16'(rd_ack), 16'd0);
    chk("c5_addr", 16'(ram_addr), 16'h102);
    chk("c5_wdata", 16'(ram_wdata), 16'd1);
    chk("c5_level", 16'(fifo_level), 16'd2);
    chk("c5_rd_data", 16'(rd_data), 16'd0);
    tick();
    chk("c6_ack", 16'(rd_ack), 16'd1);
    chk("c6_addr", 16'(ram_addr), 16'h00D);
    rd_req = 1'b0;
    tick();
    chk("c7_addr", 16'(ram_addr), 16'h103);
    chk("c7_rd_data", 16'(rd_data), 16'd1);
    chk("c7_level", 16'(fifo_level), 16'd1);
    tick();
    chk("c8_addr", 16'(ram_addr), 16'h104);
    chk("c8_wdata", 16'(ram_wdata), 16'd1);
    tick();
    chk("c9_idle_we", 16'(ram_we), 16'd0);
    chk("c9_idle_addr", 16'(ram_addr), 16'h104);
    chk("c9_wr_ptr", 16'(wr_ptr), 16'd5);

    // Overflow: reads held so the THRESH=5 instance drains only every other cycle.
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rd_req = 1'b1; rd_ptr = 8'd0; pix_we = 1'b1; pix_data = 2'(k % 4);
      tick();
      chk("ovf_lvl_max", 16'(fifo_level <= 3'd4), 16'd1);
      chk("ovf_o_lvl_max", 16'(o_fifo_level <= 3'd4), 16'd1);
      if (k == 7) chk("ovf_not_yet", 16'(o_overflow), 16'd0);
      if (k == 8) begin
        chk("ovf_set", 16'(o_overflow), 16'd1);
        chk("ovf_full", 16'(o_fifo_level), 16'd4);
      end
    end
    pix_we = 1'b0; rd_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("ovf_sticky", 16'(o_overflow), 16'd1);
    chk("ovf_drained", 16'(o_fifo_level), 16'd0);
    chk("ovf_main_clear", 16'(overflow), 16'd0);
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    chk("ovf_reset", 16'(o_overflow), 16'd0);

    // Swap in the same cycle as a pixel at wr_ptr 0x9F.
    for (int i = 0; i < 159; i++) begin
      pix_we = 1'b1; pix_data = 2'(i % 4);
      tick();
    end
    pix_we = 1'b0; mode = 2'b00;
    tick();
    chk("sw_pre_ptr", 16'(wr_ptr), 16'h9F);
    chk("sw_pre_bank", 16'(bank), 16'd0);
    mode = 2'b10; pix_we = 1'b1; pix_data = 2'b10;
    tick();
    chk("sw_bank", 16'(bank), 16'd1);
    chk("sw_wr_ptr", 16'(wr_ptr), 16'd0);
    chk("sw_level", 16'(fifo_level), 16'd1);
    pix_data = 2'b01;
    tick();
    chk("sw_old_we", 16'(ram_we), 16'd1);
    chk("sw_old_addr", 16'(ram_addr), 16'h09F);
    chk("sw_old_wdata", 16'(ram_wdata), 16'd2);
    chk("sw_next_ptr", 16'(wr_ptr), 16'd1);
    pix_we = 1'b0;
    tick();
    chk("sw_new_addr", 16'(ram_addr), 16'h100);
    chk("sw_new_wdata", 16'(ram_wdata), 16'd1);

    // Reset with a read in flight: no rd_valid afterwards.
    tick();
    rd_req = 1'b1; rd_ptr = 8'd3;
    tick();
    chk("mid_ack", 16'(rd_ack), 16'd1);
    reset_n = 1'b0; rd_req = 1'b0;
    tick();
    chk("mid_valid", 16'(rd_valid), 16'd0);
    chk("mid_bank", 16'(bank), 16'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_valid_after", 16'(rd_valid), 16'd0);
    chk("mid_level", 16'(fifo_level), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
